// File: rtl/instr_fetch_unit_if.sv
// Fetch-unit bus: instruction-memory request/response plus the decoded-instruction
// handoff and redirect inputs from the core.
interface instr_fetch_unit_if #(
    parameter int ADDR_W = 32
);
    logic              IReqValid;
    logic              IReqReady;
    logic [ADDR_W-1:0] IReqAddr;
    logic              IRspValid;
    logic [31:0]       IRspData;
    logic              InstrValid;
    logic              InstrReady;
    logic [31:0]       Instr;
    logic [ADDR_W-1:0] InstrPC;
    logic [ADDR_W-1:0] InstrPCPlus8;
    logic              PCSrc;
    logic [ADDR_W-1:0] BranchTarget;

    modport master (
        output IReqValid, IReqAddr, InstrValid, Instr, InstrPC, InstrPCPlus8,
        input  IReqReady, IRspValid, IRspData, InstrReady, PCSrc, BranchTarget
    );

    modport slave (
        input  IReqValid, IReqAddr, InstrValid, Instr, InstrPC, InstrPCPlus8,
        output IReqReady, IRspValid, IRspData, InstrReady, PCSrc, BranchTarget
    );
endinterface

// File: rtl/instr_fetch_unit.sv
// Fetch stage: owns the PC, issues in-order memory requests, buffers returned words and
// drops buffered plus in-flight wrong-path words when the core redirects.
module instr_fetch_unit #(
    parameter int                ADDR_W    = 32,
    parameter logic [ADDR_W-1:0] RESET_PC  = '0,
    parameter int                BUF_DEPTH = 2
) (
    input logic                CLK,
    input logic                RESET,
    instr_fetch_unit_if.master bus
);
    localparam int CNT_W = $clog2(BUF_DEPTH + 1);
    localparam int OCC_W = CNT_W + 1;
    localparam int PTR_W = $clog2(BUF_DEPTH);

    typedef enum logic [1:0] {ST_START, ST_RUN, ST_FLUSH} state_e;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
    logic [ADDR_W-1:0] rsp_pc_q, rsp_pc_d;
    logic [CNT_W-1:0]  out_q, out_d;
    logic [CNT_W-1:0]  drop_q, drop_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [31:0]       instr_mem_q [BUF_DEPTH];
    logic [ADDR_W-1:0] pc_mem_q    [BUF_DEPTH];

    logic              head_valid, pop, redirect;
    logic              rsp_ok, rsp_keep, rsp_drop, push;
    logic              ireq_valid, accept;
    logic [OCC_W-1:0]  occ;
    logic [ADDR_W-1:0] target;

    always_comb begin
        head_valid = (cnt_q != '0);
        pop        = head_valid && bus.InstrReady;
        redirect   = pop && bus.PCSrc;
        target     = bus.BranchTarget & ~ADDR_W'(3);
        // Responses with nothing outstanding are a protocol error and are ignored.
        rsp_ok     = bus.IRspValid && (out_q != '0);
        rsp_drop   = rsp_ok && (drop_q != '0);
        rsp_keep   = rsp_ok && (drop_q == '0);
        push       = rsp_keep && !redirect;
        // Credit the slot freed by this cycle's pop, otherwise a two-entry buffer
        // could only sustain one instruction every other cycle.
        occ        = {1'b0, out_q} + {1'b0, cnt_q} - OCC_W'(pop);
        ireq_valid = (state_q == ST_RUN) && (occ < OCC_W'(BUF_DEPTH));
        accept     = ireq_valid && bus.IReqReady;

        out_d      = out_q + CNT_W'(accept) - CNT_W'(rsp_ok);
        drop_d     = drop_q - CNT_W'(rsp_drop);
        fetch_pc_d = accept ? fetch_pc_q + ADDR_W'(4) : fetch_pc_q;
        rsp_pc_d   = rsp_keep ? rsp_pc_q + ADDR_W'(4) : rsp_pc_q;
        cnt_d      = cnt_q + CNT_W'(push) - CNT_W'(pop);
        wr_ptr_d   = wr_ptr_q + PTR_W'(push);
        rd_ptr_d   = rd_ptr_q + PTR_W'(pop);

        if (redirect) begin
            // Everything still in flight, including a request accepted this cycle, is wrong-path.
            drop_d     = out_d;
            fetch_pc_d = target;
            rsp_pc_d   = target;
            cnt_d      = '0;
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
        end

        state_d = state_q;
        case (state_q)
            ST_START: state_d = ST_RUN;
            ST_RUN:   if (redirect && (drop_d != '0)) state_d = ST_FLUSH;
            ST_FLUSH: if (drop_d == '0) state_d = ST_RUN;
            default:  state_d = ST_START;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q    <= ST_START;
            fetch_pc_q <= RESET_PC;
            rsp_pc_q   <= RESET_PC;
            out_q      <= '0;
            drop_q     <= '0;
            cnt_q      <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            rsp_pc_q   <= rsp_pc_d;
            out_q      <= out_d;
            drop_q     <= drop_d;
            cnt_q      <= cnt_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
        end
    end

    always_ff @(posedge CLK) begin
        if (push) begin
            instr_mem_q[wr_ptr_q] <= bus.IRspData;
            pc_mem_q[wr_ptr_q]    <= rsp_pc_q;
        end
    end

    assign bus.IReqValid    = ireq_valid;
    assign bus.IReqAddr     = fetch_pc_q;
    assign bus.InstrValid   = head_valid;
    assign bus.Instr        = head_valid ? instr_mem_q[rd_ptr_q] : '0;
    assign bus.InstrPC      = head_valid ? pc_mem_q[rd_ptr_q] : '0;
    assign bus.InstrPCPlus8 = head_valid ? pc_mem_q[rd_ptr_q] + ADDR_W'(8) : '0;

    a_rsp_has_req: assert property (@(posedge CLK) disable iff (RESET)
        bus.IRspValid |-> (out_q != '0));
    a_no_overflow: assert property (@(posedge CLK) disable iff (RESET)
        ({1'b0, out_q} + {1'b0, cnt_q}) <= OCC_W'(BUF_DEPTH));
endmodule
